// File: rtl/game2048_pkg.sv
// Shared types and constants for the 2048 game input/board path.
//   dir_t    : 2-bit move direction encoding seen by the board stage.
//   state_t  : move_input_ctrl FSM states.
//   BTN_*    : bit positions of each button in {U,D,L,R} vectors.
//   prio_dir : picks one direction from a rise vector, U > D > L > R.
package game2048_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_WAIT_REL
    } state_t;

    localparam int unsigned NUM_BTN = 4;
    localparam int unsigned BTN_U   = 3;
    localparam int unsigned BTN_D   = 2;
    localparam int unsigned BTN_L   = 1;
    localparam int unsigned BTN_R   = 0;

    // Only meaningful when at least one bit is set; falls through to RIGHT.
    function automatic dir_t prio_dir(input logic [NUM_BTN-1:0] rise);
        if (rise[BTN_U])      return DIR_UP;
        else if (rise[BTN_D]) return DIR_DOWN;
        else if (rise[BTN_L]) return DIR_LEFT;
        else                  return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/move_input_ctrl_btn_debounce.sv
// btn_debounce: synchronises and debounces one raw push button.
//   clk, rst_n : system clock, asynchronous active-low reset
//   btn_raw_i  : raw asynchronous button input
//   level_o    : debounced level; flips only after DEBOUNCE_CYCLES
//                consecutive synchronised samples disagree with it
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw_i,
    output logic level_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;

    // Counter runs only while the synchronised input disagrees with the
    // accepted level; any agreeing sample restarts the qualification.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/move_input_ctrl.sv
// move_input_ctrl: turns four raw direction buttons into single-shot move
// commands on a valid/ready handshake.
//   clk, rst_n         : system clock, asynchronous active-low reset
//   btn_U/D/L/R        : raw asynchronous direction buttons
//   move_valid         : a move command is pending
//   move_dir           : 00 up, 01 down, 10 left, 11 right (stable while valid)
//   move_ready         : board stage accepts the command
//   btn_level          : debounced levels {U,D,L,R}
module move_input_ctrl
    import game2048_pkg::*;
#(
    parameter  int unsigned DEBOUNCE_CYCLES = 1000000,
    localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_U,
    input  logic       btn_D,
    input  logic       btn_L,
    input  logic       btn_R,
    output logic       move_valid,
    output logic [1:0] move_dir,
    input  logic       move_ready,
    output logic [3:0] btn_level
);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_lvl;
    logic [NUM_BTN-1:0] btn_lvl_q;
    logic [NUM_BTN-1:0] btn_rise;

    state_t state_q;
    logic   valid_q;
    dir_t   dir_q;

    assign btn_raw[BTN_U] = btn_U;
    assign btn_raw[BTN_D] = btn_D;
    assign btn_raw[BTN_L] = btn_L;
    assign btn_raw[BTN_R] = btn_R;

    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw_i(btn_raw[gi]),
            .level_o  (btn_lvl[gi])
        );
    end

    assign btn_rise = btn_lvl & ~btn_lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_lvl_q <= '0;
        end else begin
            btn_lvl_q <= btn_lvl;
        end
    end

    // Rises seen outside IDLE are simply ignored, so nothing is queued;
    // the release gate in WAIT_REL provides the lockout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|btn_rise) begin
                        dir_q   <= prio_dir(btn_rise);
                        valid_q <= 1'b1;
                        state_q <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (move_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    valid_q <= 1'b0;
                    if (btn_lvl == '0) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign move_valid = valid_q;
    assign move_dir   = dir_q;
    assign btn_level  = btn_lvl;

endmodule

// File: tb/tb_move_input_ctrl.sv
module tb_move_input_ctrl;

    localparam int unsigned DB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] btn;          // {U,D,L,R}
    logic       move_ready;
    logic       move_valid;
    logic [1:0] move_dir;
    logic [3:0] btn_level;

    int errors = 0;
    int checks = 0;

    move_input_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_U     (btn[3]),
        .btn_D     (btn[2]),
        .btn_L     (btn[1]),
        .btn_R     (btn[0]),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .move_ready(move_ready),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btn;
        logic       ready;
        logic       exp_valid;
        logic [1:0] exp_dir;
        logic [3:0] exp_level;
    } vec_t;

    vec_t vecs[30];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks n cycles (inputs already driven), records valid samples and
    // checks pulse count, first pulse position and its direction.
    task automatic watch(input int n, input string name, input int exp_pulses,
                         input int exp_step, input logic [1:0] exp_dir);
        int pulses = 0;
        int first  = -1;
        logic [1:0] d = 2'b00;
        for (int i = 0; i < n; i++) begin
            tick();
            if (move_valid === 1'b1) begin
                if (pulses == 0) begin
                    first = i;
                    d     = move_dir;
                end
                pulses++;
            end
        end
        chk({name, " pulses"}, 32'(pulses), 32'(exp_pulses));
        if (exp_pulses > 0) begin
            chk({name, " step"}, 32'(first), 32'(exp_step));
            chk({name, " dir"}, 32'(d), 32'(exp_dir));
        end
    endtask

    initial begin
        int bounce_pulses;
        logic [3:0] one_btn;

        // Clean press of L with ready=1, then release. Vector k is present
        // before edge k and checked just after it.
        for (int k = 0; k < 30; k++) begin
            vecs[k].btn       = (k < 20) ? 4'b0010 : 4'b0000;
            vecs[k].ready     = 1'b1;
            vecs[k].exp_valid = (k == 6);
            vecs[k].exp_dir   = (k >= 6) ? 2'b10 : 2'b00;
            vecs[k].exp_level = (k >= 5 && k < 25) ? 4'b0010 : 4'b0000;
        end

        rst_n      = 1'b0;
        btn        = 4'b0000;
        move_ready = 1'b0;
        tick();
        tick();
        chk("reset valid", 32'(move_valid), 32'(0));
        chk("reset dir",   32'(move_dir),   32'(0));
        chk("reset level", 32'(btn_level),  32'(0));
        rst_n = 1'b1;

        for (int k = 0; k < 30; k++) begin
            btn        = vecs[k].btn;
            move_ready = vecs[k].ready;
            tick();
            chk($sformatf("clean[%0d] valid", k), 32'(move_valid), 32'(vecs[k].exp_valid));
            chk($sformatf("clean[%0d] dir", k),   32'(move_dir),   32'(vecs[k].exp_dir));
            chk($sformatf("clean[%0d] level", k), 32'(btn_level),  32'(vecs[k].exp_level));
        end

        // Bounce on R: 2 high, 2 low for 12 cycles, then held.
        move_ready    = 1'b1;
        bounce_pulses = 0;
        for (int i = 0; i < 12; i++) begin
            btn = ((i / 2) % 2 == 0) ? 4'b0001 : 4'b0000;
            tick();
            if (move_valid === 1'b1) bounce_pulses++;
            chk($sformatf("bounce[%0d] level", i), 32'(btn_level), 32'(0));
        end
        chk("bounce pulses during glitches", 32'(bounce_pulses), 32'(0));
        btn = 4'b0001;
        watch(14, "bounce hold", 1, 6, 2'b11);
        btn = 4'b0000;
        watch(10, "bounce release", 0, 0, 2'b00);

        // Backpressure on U.
        move_ready = 1'b0;
        btn        = 4'b1000;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("bp pre[%0d] valid", i), 32'(move_valid), 32'(0));
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("bp hold[%0d] valid", i), 32'(move_valid), 32'(1));
            chk($sformatf("bp hold[%0d] dir", i),   32'(move_dir),   32'(0));
        end
        move_ready = 1'b1;
        tick();
        chk("bp drop valid", 32'(move_valid), 32'(0));
        btn = 4'b0000;
        watch(10, "bp release", 0, 0, 2'b00);
        chk("bp level idle", 32'(btn_level), 32'(0));

        // Simultaneous D+R, then lockout while R is still held.
        btn = 4'b0101;
        watch(10, "simul", 1, 6, 2'b01);
        chk("simul level", 32'(btn_level), 32'(4'b0101));
        btn = 4'b0001;
        watch(15, "lockout R held", 0, 0, 2'b00);
        btn = 4'b0000;
        watch(10, "lockout release", 0, 0, 2'b00);
        btn = 4'b0001;
        watch(10, "rearm R", 1, 6, 2'b11);
        btn = 4'b0000;
        watch(10, "rearm release", 0, 0, 2'b00);

        // Reset while a move is pending.
        move_ready = 1'b0;
        btn        = 4'b1000;
        for (int i = 0; i < 7; i++) tick();
        chk("rst pend valid", 32'(move_valid), 32'(1));
        chk("rst pend dir",   32'(move_dir),   32'(0));
        rst_n = 1'b0;
        #1;
        chk("rst async valid", 32'(move_valid), 32'(0));
        chk("rst async level", 32'(btn_level),  32'(0));
        chk("rst async dir",   32'(move_dir),   32'(0));
        tick();
        tick();
        rst_n      = 1'b1;
        move_ready = 1'b1;
        watch(10, "post reset", 1, 6, 2'b00);
        btn = 4'b0000;
        watch(10, "post reset release", 0, 0, 2'b00);

        // Repeated presses U, D, L, R.
        for (int j = 0; j < 4; j++) begin
            one_btn = 4'b1000 >> j;
            btn     = one_btn;
            watch(8, $sformatf("repeat%0d press", j), 1, 6, 2'(j));
            btn = 4'b0000;
            watch(10, $sformatf("repeat%0d gap", j), 0, 0, 2'b00);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
